// File: rtl/tile_input_conditioner_pkg.sv
// rtl/tile_input_conditioner_pkg.sv - shared constants and event priority for the tile input conditioner
package tile_input_conditioner_pkg;

  localparam int KEY_RESTART         = 0;
  localparam int KEY_FIRST           = 1;
  localparam int KEY_SECOND          = 2;
  localparam int NUM_KEYS            = 3;
  localparam int DEBOUNCE_CYCLES_DEF = 500000;
  localparam int NSW_DEF             = 10;
  localparam int IDX_W_DEF           = 4;

  typedef enum logic [1:0] {
    EV_NONE,
    EV_RESTART,
    EV_FIRST,
    EV_SECOND
  } key_event_e;

  // Restart masks picks; a simultaneous second pick is dropped in favour of first.
  function automatic key_event_e select_event(input logic [NUM_KEYS-1:0] press);
    if (press[KEY_RESTART])     return EV_RESTART;
    else if (press[KEY_FIRST])  return EV_FIRST;
    else if (press[KEY_SECOND]) return EV_SECOND;
    else                        return EV_NONE;
  endfunction

endpackage

// File: rtl/tile_input_conditioner_debounce_cell.sv
// rtl/tile_input_conditioner_debounce_cell.sv - two-flop synchroniser with whole-vector stability debounce
module debounce_cell #(
  parameter int               WIDTH     = 1,
  parameter int               CYCLES    = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int CNT_W = $clog2(CYCLES);

  logic [WIDTH-1:0] sync1_q, sync2_q, cand_q, held_q, held_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // cand_q is last cycle's synced value; a change restarts the count at 1.
  always_comb begin
    held_d = held_q;
    cnt_d  = cnt_q;
    if (sync2_q == held_q) begin
      cnt_d = '0;
    end else if (sync2_q != cand_q) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q == CNT_W'(CYCLES - 1)) begin
      held_d = sync2_q;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= RESET_VAL;
      sync2_q <= RESET_VAL;
      cand_q  <= RESET_VAL;
      held_q  <= RESET_VAL;
      cnt_q   <= '0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      cand_q  <= sync2_q;
      held_q  <= held_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dout = held_q;

endmodule

// File: rtl/tile_input_conditioner.sv
// rtl/tile_input_conditioner.sv - debounced key press events and one-hot tile selection encoder
module tile_input_conditioner
  import tile_input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int NSW             = NSW_DEF,
  parameter int IDX_W           = IDX_W_DEF
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  input  logic [NUM_KEYS-1:0] key_n,
  input  logic [NSW-1:0]      sw,
  output logic                restart,
  output logic                pick_first,
  output logic                pick_second,
  output logic [IDX_W-1:0]    pick_idx,
  output logic                pick_err,
  output logic                sel_valid,
  output logic [NUM_KEYS-1:0] key_level
);

  logic [NUM_KEYS-1:0] key_db_n;
  logic [NSW-1:0]      sw_held;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    debounce_cell #(
      .WIDTH    (1),
      .CYCLES   (DEBOUNCE_CYCLES),
      .RESET_VAL(1'b1)
    ) u_key_db (
      .clk  (CLOCK_50),
      .rst_n(resetn),
      .din  (key_n[g]),
      .dout (key_db_n[g])
    );
  end

  debounce_cell #(
    .WIDTH    (NSW),
    .CYCLES   (DEBOUNCE_CYCLES),
    .RESET_VAL('0)
  ) u_sw_db (
    .clk  (CLOCK_50),
    .rst_n(resetn),
    .din  (sw),
    .dout (sw_held)
  );

  logic [NUM_KEYS-1:0] key_level_q, key_prev_q, press;
  logic [IDX_W-1:0]    sel_idx, idx_q, idx_d;
  logic                restart_q, first_q, second_q, err_q;
  logic                restart_d, first_d, second_d, err_d;

  assign sel_valid = $onehot(sw_held);
  assign press     = key_level_q & ~key_prev_q;

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NSW; i++) begin
      if (sw_held[i]) sel_idx = IDX_W'(i);
    end
  end

  always_comb begin
    restart_d = 1'b0;
    first_d   = 1'b0;
    second_d  = 1'b0;
    err_d     = 1'b0;
    idx_d     = idx_q;
    case (select_event(press))
      EV_RESTART: restart_d = 1'b1;
      EV_FIRST: begin
        if (sel_valid) begin
          first_d = 1'b1;
          idx_d   = sel_idx;
        end else begin
          err_d = 1'b1;
        end
      end
      EV_SECOND: begin
        if (sel_valid) begin
          second_d = 1'b1;
          idx_d    = sel_idx;
        end else begin
          err_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      key_level_q <= '0;
      key_prev_q  <= '0;
      restart_q   <= 1'b0;
      first_q     <= 1'b0;
      second_q    <= 1'b0;
      err_q       <= 1'b0;
      idx_q       <= '0;
    end else begin
      key_level_q <= ~key_db_n;
      key_prev_q  <= key_level_q;
      restart_q   <= restart_d;
      first_q     <= first_d;
      second_q    <= second_d;
      err_q       <= err_d;
      idx_q       <= idx_d;
    end
  end

  assign restart     = restart_q;
  assign pick_first  = first_q;
  assign pick_second = second_q;
  assign pick_err    = err_q;
  assign pick_idx    = idx_q;
  assign key_level   = key_level_q;

endmodule
